// File: rtl/commit_trace_buffer_pkg.sv
// Shared types for the commit trace buffer: record layout, FSM states, lane field widths.
// Latency: n/a (types only).
// Backpressure: n/a.
package commit_trace_buffer_pkg;

  // Record timestamp width; the buffer's TSW counter is sized into this field.
  localparam int TS_W = 16;
  localparam int XLEN = 32;
  localparam int RW   = 5;
  // Wide enough to count up to four retire lanes.
  localparam int LCW  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } trace_state_e;

  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            rdv;
    logic [RW-1:0]   rd_x;
    logic [XLEN-1:0] rd_data;
    logic            pcv;
    logic [XLEN-1:0] pc_x;
  } trace_rec_t;

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Retire-lane snoop bus plus the drain port of the commit trace buffer.
// Latency: n/a (wires only).
// Backpressure: drain port is valid/ready; the retire lanes cannot be stalled.
interface commit_trace_buffer_if #(
  parameter int NRET = 1
) ();
  import commit_trace_buffer_pkg::*;

  logic [NRET-1:0]           valid;
  logic [NRET-1:0][XLEN-1:0] pc;
  logic [NRET-1:0][XLEN-1:0] inst;
  logic [NRET-1:0]           rdv;
  logic [NRET-1:0][RW-1:0]   rd_x;
  logic [NRET-1:0][XLEN-1:0] rd_data;
  logic [NRET-1:0]           pcv;
  logic [NRET-1:0][XLEN-1:0] pc_x;
  logic                      out_valid;
  logic                      out_ready;
  trace_rec_t                out_rec;

  modport master (
    output valid, pc, inst, rdv, rd_x, rd_data, pcv, pc_x, out_ready,
    input  out_valid, out_rec
  );

  modport slave (
    input  valid, pc, inst, rdv, rd_x, rd_data, pcv, pc_x, out_ready,
    output out_valid, out_rec
  );
endinterface

// File: rtl/commit_trace_buffer_lane_compact.sv
// Packs eligible retire lanes into consecutive slots and ranks the first trigger among them.
// Latency: purely combinational.
// Backpressure: none.
module commit_trace_buffer_lane_compact
  import commit_trace_buffer_pkg::*;
#(
  parameter int NRET = 1
) (
  input  logic [NRET-1:0]          elig,
  input  logic [NRET-1:0]          fire,
  input  logic                     ext,
  output logic [NRET-1:0][LCW-1:0] offset,
  output logic [LCW-1:0]           wr_cnt,
  output logic                     trig_hit,
  output logic [LCW-1:0]           trig_rank
);

  logic [LCW-1:0] run;

  // Prefix-count eligible lanes; trigger rank = eligible records up to and including the trigger.
  // The external strobe ranks as the last eligible lane, so any PC match on a lane wins over it.
  always_comb begin
    run       = '0;
    trig_hit  = 1'b0;
    trig_rank = '0;
    for (int i = 0; i < NRET; i++) begin
      offset[i] = run;
      if (elig[i]) run = run + LCW'(1);
      if (fire[i] && !trig_hit) begin
        trig_hit  = 1'b1;
        trig_rank = run;
      end
    end
    wr_cnt = run;
    if (ext && !trig_hit) begin
      trig_hit  = 1'b1;
      trig_rank = run;
    end
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Circular capture of retire records around a trigger; freezes and drains oldest-first.
// Latency: records land one cycle after retire; drain data is combinational from storage.
// Backpressure: drain holds while out_ready=0; capture never stalls and overwrites the oldest.
module commit_trace_buffer
  import commit_trace_buffer_pkg::*;
#(
  parameter int NRET  = 1,
  parameter int DEPTH = 16,
  parameter int POST  = 4,
  parameter int TSW   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     trig_en,
  input  logic [XLEN-1:0]          trig_pc,
  input  logic                     trig_ext,
  commit_trace_buffer_if.slave     bus,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     wrapped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  trace_state_e            st, st_n;
  logic [AW-1:0]           wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [CW-1:0]           cnt_n, post_cnt, post_n;
  logic                    wrapped_n;
  logic [TSW-1:0]          ts_cnt;
  logic [NRET-1:0]         elig, fire, we;
  logic [NRET-1:0][LCW-1:0] offset;
  logic [LCW-1:0]          wr_cnt, trig_rank;
  logic                    trig_hit;
  int                      lim, total;
  trace_rec_t              mem [DEPTH];

  // Per-lane eligibility and PC-match trigger candidates.
  always_comb begin
    for (int i = 0; i < NRET; i++) begin
      elig[i] = bus.valid[i] | bus.rdv[i] | bus.pcv[i];
      fire[i] = trig_en & bus.valid[i] & (bus.pc[i] == trig_pc);
    end
  end

  commit_trace_buffer_lane_compact #(.NRET(NRET)) u_compact (
    .elig      (elig),
    .fire      (fire),
    .ext       (trig_ext),
    .offset    (offset),
    .wr_cnt    (wr_cnt),
    .trig_hit  (trig_hit),
    .trig_rank (trig_rank)
  );

  // Next state: lim is how many eligible lanes (in order) are written this cycle.
  always_comb begin
    st_n      = st;
    wr_ptr_n  = wr_ptr;
    rd_ptr_n  = rd_ptr;
    cnt_n     = count;
    wrapped_n = wrapped;
    post_n    = post_cnt;
    lim       = 0;
    total     = 0;
    if (arm) begin
      st_n      = ST_ARMED;
      wr_ptr_n  = '0;
      rd_ptr_n  = '0;
      cnt_n     = '0;
      wrapped_n = 1'b0;
      post_n    = '0;
    end else begin
      case (st)
        ST_ARMED: begin
          lim = int'(wr_cnt);
          if (trig_hit) begin
            // Trigger record and lanes below it, plus up to POST lanes above it.
            if (int'(trig_rank) + POST < lim) lim = int'(trig_rank) + POST;
            post_n = CW'(lim - int'(trig_rank));
            st_n   = (lim - int'(trig_rank) == POST) ? ST_FROZEN : ST_POST;
          end
        end
        ST_POST: begin
          lim = int'(wr_cnt);
          if (POST - int'(post_cnt) < lim) lim = POST - int'(post_cnt);
          post_n = CW'(int'(post_cnt) + lim);
          if (int'(post_cnt) + lim == POST) st_n = ST_FROZEN;
        end
        ST_FROZEN: begin
          if (bus.out_valid && bus.out_ready) begin
            rd_ptr_n = rd_ptr + AW'(1);
            cnt_n    = count - CW'(1);
            if (count == CW'(1)) st_n = ST_IDLE;
          end
        end
        default: ;
      endcase
      total = int'(count) + lim;
      if (lim != 0) begin
        wr_ptr_n = wr_ptr + AW'(lim);
        if (total > DEPTH) begin
          // Overflow: oldest records are overwritten, read side slides forward.
          rd_ptr_n  = rd_ptr + AW'(total - DEPTH);
          cnt_n     = CW'(DEPTH);
          wrapped_n = 1'b1;
        end else begin
          cnt_n = CW'(total);
        end
      end
    end
  end

  // Lane write enables: the first lim eligible lanes only.
  always_comb begin
    for (int i = 0; i < NRET; i++) we[i] = elig[i] && (int'(offset[i]) < lim);
  end

  // Capture: each written lane lands offset[i] slots past the write pointer.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NRET; i++) begin
      if (we[i]) begin
        mem[wr_ptr + AW'(offset[i])] <= '{
          ts:      TS_W'(ts_cnt),
          valid:   bus.valid[i],
          pc:      bus.pc[i],
          inst:    bus.inst[i],
          rdv:     bus.rdv[i],
          rd_x:    bus.rd_x[i],
          rd_data: bus.rd_data[i],
          pcv:     bus.pcv[i],
          pc_x:    bus.pc_x[i]
        };
      end
    end
  end

  // Control state and free-running timestamp.
  always_ff @(posedge clk) begin
    if (!reset) begin
      st       <= ST_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wrapped  <= 1'b0;
      post_cnt <= '0;
      ts_cnt   <= '0;
    end else begin
      st       <= st_n;
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      count    <= cnt_n;
      wrapped  <= wrapped_n;
      post_cnt <= post_n;
      ts_cnt   <= ts_cnt + TSW'(1);
    end
  end

  assign state         = st;
  assign bus.out_valid = (st == ST_FROZEN) && (count != '0);
  assign bus.out_rec   = mem[rd_ptr];

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer with NRET=2, DEPTH=4, POST=2.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: out_ready is driven explicitly per step.
module tb_commit_trace_buffer;
  import commit_trace_buffer_pkg::*;

  localparam int NRET  = 2;
  localparam int DEPTH = 4;
  localparam int POST  = 2;
  localparam int TSW   = 16;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic        arm      = 1'b0;
  logic        trig_en  = 1'b0;
  logic [31:0] trig_pc  = '0;
  logic        trig_ext = 1'b0;
  logic [1:0]  state;
  logic [2:0]  count;
  logic        wrapped;
  int          passed = 0;
  int          total  = 0;
  logic [TS_W-1:0] ts_a, ts_b, ts_c;
  logic [31:0] exp_b [4];
  logic [31:0] exp_c [3];

  commit_trace_buffer_if #(.NRET(NRET)) bus ();

  commit_trace_buffer #(.NRET(NRET), .DEPTH(DEPTH), .POST(POST), .TSW(TSW)) dut (
    .clk      (clk),
    .reset    (reset),
    .arm      (arm),
    .trig_en  (trig_en),
    .trig_pc  (trig_pc),
    .trig_ext (trig_ext),
    .bus      (bus),
    .state    (state),
    .count    (count),
    .wrapped  (wrapped)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle_lanes();
    bus.valid   = '0;
    bus.rdv     = '0;
    bus.pcv     = '0;
    bus.pc      = '0;
    bus.inst    = '0;
    bus.rd_x    = '0;
    bus.rd_data = '0;
    bus.pc_x    = '0;
  endtask

  task automatic set_lane(input int l, input logic [31:0] p);
    bus.valid[l] = 1'b1;
    bus.pc[l]    = p;
    bus.inst[l]  = p ^ 32'hA5A5_0000;
  endtask

  task automatic ret1(input logic [31:0] p);
    idle_lanes();
    set_lane(0, p);
    tick();
    idle_lanes();
  endtask

  initial begin
    // Reset held with everything active
    idle_lanes();
    bus.out_ready = 1'b1;
    arm = 1'b1; trig_ext = 1'b1; trig_en = 1'b1; trig_pc = 32'h84;
    set_lane(0, 32'h80); set_lane(1, 32'h84);
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_count", count, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_wrapped", wrapped, 0);

    // Out of reset, not armed: retires (even matching trig_pc) are ignored
    reset = 1'b1; arm = 1'b0; trig_ext = 1'b0; bus.out_ready = 1'b0;
    for (int k = 0; k < 10; k++) ret1(32'h80 + 32'(4 * k));
    chk("idle_count", count, 0);
    chk("idle_state", state, 0);

    // A: the arm cycle record is dropped; trigger at 0x108, two post records
    trig_en = 1'b1; trig_pc = 32'h108;
    ret1(32'h100);
    arm = 1'b1; ret1(32'h104); arm = 1'b0;
    chk("A_armed", state, 1);
    chk("A_arm_count", count, 0);
    ret1(32'h108);
    chk("A_post", state, 2);
    ret1(32'h10C);
    ret1(32'h110);
    chk("A_frozen", state, 3);
    chk("A_count", count, 3);
    chk("A_wrapped", wrapped, 0);
    bus.out_ready = 1'b1;
    chk("A_out_valid", bus.out_valid, 1);
    chk("A_pc0", bus.out_rec.pc, 32'h108);
    chk("A_inst0", bus.out_rec.inst, 32'h108 ^ 32'hA5A5_0000);
    ts_a = bus.out_rec.ts; tick();
    chk("A_pc1", bus.out_rec.pc, 32'h10C);
    ts_b = bus.out_rec.ts; tick();
    chk("A_pc2", bus.out_rec.pc, 32'h110);
    ts_c = bus.out_rec.ts; tick();
    chk("A_ts_step1", ts_b - ts_a, 1);
    chk("A_ts_step2", ts_c - ts_b, 1);
    chk("A_idle_after_drain", state, 0);
    chk("A_out_valid_end", bus.out_valid, 0);
    bus.out_ready = 1'b0;

    // B: overflow before trigger keeps the newest DEPTH records
    trig_pc = 32'h218;
    arm = 1'b1; tick(); arm = 1'b0;
    for (int k = 0; k < 9; k++) ret1(32'h200 + 32'(4 * k));
    chk("B_frozen", state, 3);
    chk("B_count", count, 4);
    chk("B_wrapped", wrapped, 1);
    exp_b[0] = 32'h214; exp_b[1] = 32'h218; exp_b[2] = 32'h21C; exp_b[3] = 32'h220;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("B_pc%0d", k), bus.out_rec.pc, exp_b[k]);
      tick();
    end
    chk("B_idle", state, 0);
    bus.out_ready = 1'b0;

    // C: dual-lane trigger on lane0; second post cycle keeps only lane0
    trig_pc = 32'h300;
    arm = 1'b1; tick(); arm = 1'b0;
    set_lane(0, 32'h300); set_lane(1, 32'h304); tick(); idle_lanes();
    chk("C_post", state, 2);
    chk("C_post_count", count, 2);
    set_lane(0, 32'h308); set_lane(1, 32'h30C); tick(); idle_lanes();
    chk("C_frozen", state, 3);
    chk("C_count", count, 3);
    exp_c[0] = 32'h300; exp_c[1] = 32'h304; exp_c[2] = 32'h308;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("C_pc%0d", k), bus.out_rec.pc, exp_c[k]);
      tick();
    end
    chk("C_idle", state, 0);
    bus.out_ready = 1'b0;

    // D: register-write-only record on lane1, external trigger, wrap
    trig_en = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    ret1(32'h3FC);
    bus.rdv[1] = 1'b1; bus.rd_x[1] = 5'd5; bus.rd_data[1] = 32'hDEADBEEF;
    tick(); idle_lanes();
    chk("D_count2", count, 2);
    chk("D_still_armed", state, 1);
    trig_ext = 1'b1; set_lane(0, 32'h400); tick(); trig_ext = 1'b0; idle_lanes();
    chk("D_ext_post", state, 2);
    chk("D_count3", count, 3);
    set_lane(0, 32'h404); set_lane(1, 32'h408); tick(); idle_lanes();
    chk("D_frozen", state, 3);
    chk("D_count4", count, 4);
    chk("D_wrapped", wrapped, 1);
    chk("D_rec_valid", bus.out_rec.valid, 0);
    chk("D_rec_rdv", bus.out_rec.rdv, 1);
    chk("D_rec_rd_x", bus.out_rec.rd_x, 5);
    chk("D_rec_rd_data", bus.out_rec.rd_data, 32'hDEADBEEF);

    // Drain with ready 1/0/1, then arm mid-drain
    bus.out_ready = 1'b1; tick();
    chk("D_hs1_count", count, 3);
    chk("D_hs1_pc", bus.out_rec.pc, 32'h400);
    bus.out_ready = 1'b0; tick();
    chk("D_hold_count", count, 3);
    chk("D_hold_valid", bus.out_valid, 1);
    chk("D_hold_pc", bus.out_rec.pc, 32'h400);
    bus.out_ready = 1'b1; tick();
    chk("D_hs2_count", count, 2);
    chk("D_hs2_pc", bus.out_rec.pc, 32'h404);
    arm = 1'b1; tick(); arm = 1'b0; bus.out_ready = 1'b0;
    chk("D_rearm_valid", bus.out_valid, 0);
    chk("D_rearm_state", state, 1);
    chk("D_rearm_count", count, 0);
    chk("D_rearm_wrapped", wrapped, 0);

    // External trigger with no eligible lane: POST entered, nothing written
    trig_ext = 1'b1; tick(); trig_ext = 1'b0;
    chk("E_post", state, 2);
    chk("E_count0", count, 0);
    ret1(32'h500);
    chk("E_post_still", state, 2);
    chk("E_count1", count, 1);
    ret1(32'h504);
    chk("E_frozen", state, 3);
    chk("E_count2", count, 2);
    chk("E_pc0", bus.out_rec.pc, 32'h500);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
